// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS datapath: PC register, next-PC
// candidates and mux select, with boot cycle, halt state, stall gating and a branch counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 branch,
  input  logic                 zero,
  input  logic                 jump,
  input  logic                 halt,
  input  logic [31:0]          imm,
  input  logic [25:0]          jump_index,
  input  logic [31:0]          next_pc,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          pc_branch,
  output logic [31:0]          pc_jump,
  output logic [1:0]           pc_src,
  output logic                 instr_valid,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] branch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [1:0] SRC_PLUS4  = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state;

  // Candidate targets are valid in every state; the imm shift drops its top two bits.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    pc_branch = pc_plus4 + (imm << 2);
    pc_jump   = {pc_plus4[31:28], jump_index, 2'b00};
  end

  // NOTE: pc_src gets a default before any condition so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pc_src = SRC_PLUS4;
    if (state == RUN) begin
      if (jump)
        pc_src = SRC_JUMP;
      else if (branch && zero)
        pc_src = SRC_BRANCH;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      branch_count <= '0;
      instr_valid  <= 1'b0;
      halted       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          instr_valid <= 1'b1;
        end
        RUN: begin
          if (en) begin
            if (halt) begin
              // The halt instruction's own address is kept for inspection.
              state       <= HALT;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end else begin
              pc <= next_pc;
              if (pc_src == SRC_BRANCH && branch_count != CNT_MAX)
                branch_count <= branch_count + CNT_WIDTH'(1);
            end
          end
        end
        HALT: ;
        default: begin
          state       <= BOOT;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle MIPS datapath. Holds the PC register, computes the three next-PC candidates (PC+4, branch target, jump target), and drives the 2-bit select into the existing 3:1 next-PC multiplexer, taking the multiplexer output back as `next_pc`. It also adds a boot cycle after reset, a halt state, stall gating and a saturating taken-branch counter.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `CNT_WIDTH`, default 16, width of the taken-branch counter.

Ports:
- `clk`, input, 1, the single clock, rising-edge.
- `rst`, input, 1, asynchronous, active-high reset.
- `en`, input, 1, advance enable; 0 = stall, all registers hold.
- `branch`, input, 1, decoded BEQ.
- `zero`, input, 1, ALU zero flag for the current instruction.
- `jump`, input, 1, decoded J.
- `halt`, input, 1, decoded halt instruction.
- `imm`, input, 32, sign-extended 16-bit immediate (word offset).
- `jump_index`, input, 26, instruction bits [25:0].
- `next_pc`, input, 32, output of the external 3:1 multiplexer.
- `pc`, output, 32, current PC (registered).
- `pc_plus4`, output, 32, `pc + 4`, mod 2^32 (multiplexer in0).
- `pc_branch`, output, 32, `pc_plus4 + (imm << 2)`, mod 2^32 (multiplexer in1).
- `pc_jump`, output, 32, `{pc_plus4[31:28], jump_index, 2'b00}` (multiplexer in2).
- `pc_src`, output, 2, multiplexer select: 00 = PC+4, 01 = branch, 10 = jump; 11 is never driven.
- `instr_valid`, output, 1, high only in RUN.
- `halted`, output, 1, high in HALT.
- `branch_count`, output, CNT_WIDTH, number of taken branches, saturating.

## Operation
- States:
  - BOOT: reset state.
  - RUN.
  - HALT.
- State transitions:
  - BOOT → RUN unconditionally on the first rising edge after `rst` deasserts. `en` is ignored for this transition.
  - RUN → HALT on an edge with `en=1 && halt=1`.
  - HALT exits only via `rst`.
  - `en=0` holds the current state.
- `pc_src` is combinational:
  - Outside RUN: 00.
  - In RUN: 10 if `jump`; otherwise 01 if `branch && zero`; otherwise 00.
  - `jump` has priority over a taken branch.
- `pc_plus4`, `pc_branch` and `pc_jump` are combinational from `pc`, `imm` and `jump_index`. They are valid in every state. All arithmetic wraps mod 2^32.
- PC update:
  - `pc` loads `next_pc` on an edge where state is RUN, `en=1` and `halt=0`.
  - In all other cases `pc` holds. This includes BOOT, HALT, the halting edge and stalls.
  - On halt, `pc` stays at the address of the halt instruction.
- Branch counter:
  - `branch_count` increments on an edge where state is RUN, `en=1`, `halt=0` and `pc_src==01`.
  - It saturates at all-ones.
  - A jump with `branch && zero` both high does not count.
- `next_pc` is not checked. The block loads whatever the multiplexer returns.

## Timing
- Reset values while `rst` is high, applied asynchronously:
  - `pc=RESET_PC`, state BOOT, `branch_count=0`, `halted=0`, `instr_valid=0`, `pc_src=00`.
  - Combinational outputs follow from `pc=RESET_PC`.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge. Any in-flight update is discarded.
- Latency:
  - Decode inputs to `pc_src`: 0 cycles (combinational).
  - `next_pc` to `pc`: 1 edge.
  - First instruction is presented in the cycle after the BOOT edge, with `pc=RESET_PC` and `instr_valid=1`.
- Stall: `en=0` freezes `pc`, state and `branch_count`. `pc_src` and the targets keep tracking their inputs.
- `halt` and `jump` on the same edge: halt wins and `pc` holds.
- PC wrap-around: `pc=32'hFFFF_FFFC` gives `pc_plus4=0`.

## Test plan
- Reset and boot: assert `rst`, release, hold `en=1`, and check across three edges:
  - Edge 1: `pc=0`, `instr_valid=0`.
  - Edge 2: `instr_valid=1` with `pc_src=00`, and `pc` advances to 4 on the following edge.
- Taken and untaken branch at `pc=32'h10`, `imm=32'hFFFF_FFFE`:
  - `branch=1, zero=1` → `pc_src=01`, `pc_branch=32'h0C`, `pc` becomes `32'h0C`, `branch_count=1`.
  - `zero=0` → `pc_src=00`, `pc=32'h14`.
- Jump priority at `pc=32'hA000_0000`, `jump_index=26'h000_0040`, with `branch=zero=jump=1`:
  - `pc_src=10`, `pc_jump=32'hA000_0100`.
  - `branch_count` unchanged.
- Stall then halt:
  - `en=0` for 3 cycles → `pc` and `branch_count` frozen.
  - Then `en=1, halt=1, jump=1` at `pc=32'h20` → `halted=1`, `instr_valid=0`, `pc` stays `32'h20` indefinitely.
- Counter saturation and async reset:
  - With `CNT_WIDTH=2`, 5 taken branches → `branch_count=3`.
  - Pulse `rst` between clock edges → `pc=RESET_PC`, `branch_count=0` immediately.
- Wrap-around: `pc=32'hFFFF_FFFC`, no branch or jump → `pc_plus4=0`, and `pc` becomes 0.
